// File: rtl/mant24_div_seq.sv
// Sequential radix-2 restoring mantissa divider: q = floor(a*2^F/b), one quotient bit per clock.
// Divide-by-zero and overflow are resolved in the accept cycle without entering RUN.
module mant24_div_seq #(
   parameter int W = 24,
   parameter int F = 25
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [F:0]   q,
   output logic [W-1:0] r,
   output logic         sticky,
   output logic         ovf,
   output logic         dbz
);

   localparam int CW = $clog2(F + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t         state_q, state_d;
   logic [W:0]     rem_q, rem_d;
   logic [W-1:0]   div_q, div_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [F:0]     acc_q, acc_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [F:0]     q_q, q_d;
   logic [W-1:0]   r_q, r_d;
   logic           sticky_q, sticky_d;
   logic           ovf_q, ovf_d;
   logic           dbz_q, dbz_d;

   logic [W:0]     a_ext, b_dbl, div_ext, rem_sub, rem_new;
   logic [F:0]     acc_new;
   logic           take;

   always_comb begin
      a_ext   = {1'b0, a};
      b_dbl   = {b, 1'b0};
      div_ext = {1'b0, div_q};
      take    = (rem_q >= div_ext);
      rem_sub = rem_q - div_ext;
      rem_new = take ? rem_sub : rem_q;
      acc_new = {acc_q[F-1:0], take};

      state_d  = state_q;
      rem_d    = rem_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      q_d      = q_q;
      r_d      = r_q;
      sticky_d = sticky_q;
      ovf_d    = ovf_q;
      dbz_d    = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (b == '0) begin
                  dbz_d    = 1'b1;
                  ovf_d    = 1'b0;
                  q_d      = '1;
                  r_d      = '0;
                  sticky_d = 1'b0;
                  done_d   = 1'b1;
               end else if (a_ext >= b_dbl) begin
                  // quotient would need more than F+1 bits: saturate immediately
                  ovf_d    = 1'b1;
                  dbz_d    = 1'b0;
                  q_d      = '1;
                  r_d      = '0;
                  sticky_d = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  rem_d   = a_ext;
                  div_d   = b;
                  cnt_d   = CW'(F);
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  dbz_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            acc_d = acc_new;
            if (cnt_q == '0) begin
               q_d      = acc_new;
               r_d      = rem_new[W-1:0];
               sticky_d = |rem_new;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end else begin
               // rem_new < divisor, so the doubled value still fits in W+1 bits
               rem_d = {rem_new[W-1:0], 1'b0};
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         q_q      <= '0;
         r_q      <= '0;
         sticky_q <= 1'b0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         q_q      <= q_d;
         r_q      <= r_d;
         sticky_q <= sticky_d;
         ovf_q    <= ovf_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign q      = q_q;
   assign r      = r_q;
   assign sticky = sticky_q;
   assign ovf    = ovf_q;
   assign dbz    = dbz_q;

endmodule

// File: tb/tb_mant24_div_seq.sv
// Directed and randomized checks of mant24_div_seq against an arithmetic reference model.
module tb_mant24_div_seq;

   localparam int W = 24;
   localparam int F = 25;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [F:0]    q;
   logic [W-1:0]  r;
   logic          sticky;
   logic          ovf;
   logic          dbz;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int k_cyc = 0;
   int done_cyc = 0;
   logic busy_at_k = 1'b0;

   mant24_div_seq #(.W(W), .F(F)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .q(q), .r(r), .sticky(sticky), .ovf(ovf), .dbz(dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division of the scaled dividend.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 output logic [F:0] eq, output logic [W-1:0] er,
                                 output logic es, output logic eo, output logic ed,
                                 output int elat);
      longint unsigned num, den;
      num = 64'(ma) << F;
      den = 64'(mb);
      eo = 1'b0; ed = 1'b0; es = 1'b0; er = '0; eq = '1; elat = 0;
      if (mb == '0) begin
         ed = 1'b1;
      end else if (64'(ma) >= 2 * den) begin
         eo = 1'b1;
      end else begin
         eq   = (F+1)'(num / den);
         er   = W'(num % den);
         es   = (er != '0);
         elat = F + 1;
      end
   endfunction

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb);
      start = 1'b1; a = ta; b = tb;
      @(posedge clk);
      @(negedge clk);
      k_cyc = cyc;
      busy_at_k = busy;
      start = 1'b0; a = W'($urandom); b = W'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      done_cyc = (done === 1'b1) ? cyc : -1000;
   endtask

   task automatic run_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic [F:0] eq, input logic [W-1:0] er, input logic es,
                            input logic eo, input logic ed, input int elat);
      start_op(ta, tb);
      check({tag, ".busy_k"}, 64'(busy_at_k), 64'(elat != 0));
      wait_done();
      check({tag, ".lat"}, 64'(done_cyc - k_cyc), 64'(elat));
      check({tag, ".q"}, 64'(q), 64'(eq));
      check({tag, ".r"}, 64'(r), 64'(er));
      check({tag, ".flags"}, 64'({sticky, ovf, dbz, busy}), 64'({es, eo, ed, 1'b0}));
      $display("op %s a=%h b=%h q=%h r=%h sticky=%0d ovf=%0d dbz=%0d lat=%0d",
               tag, ta, tb, q, r, sticky, ovf, dbz, done_cyc - k_cyc);
   endtask

   initial begin
      logic [F:0]   eq;
      logic [W-1:0] er, ra, rb;
      logic         es, eo, ed;
      int           elat, dcount, mode;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset.q", 64'(q), 64'd0);
      check("reset.r", 64'(r), 64'd0);
      check("reset.flags", 64'({busy, done, sticky, ovf, dbz}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_check("one", 24'h800000, 24'h800000, 26'h2000000, 24'h0, 1'b0, 1'b0, 1'b0, 26);
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
      run_check("1p5", 24'hC00000, 24'h800000, 26'h3000000, 24'h0, 1'b0, 1'b0, 1'b0, 26);
      @(negedge clk);
      run_check("2of3", 24'h800000, 24'hC00000, 26'h1555555, 24'h400000, 1'b1, 1'b0, 1'b0, 26);
      @(negedge clk);
      run_check("ovf", 24'hFFFFFF, 24'h7FFFFF, 26'h3FFFFFF, 24'h0, 1'b0, 1'b1, 1'b0, 0);
      @(negedge clk);
      check("ovf.done_clear", 64'(done), 64'd0);
      run_check("dbz", 24'h123456, 24'h000000, 26'h3FFFFFF, 24'h0, 1'b0, 1'b0, 1'b1, 0);
      @(negedge clk);

      // start while busy is ignored; start in the done cycle is accepted
      start_op(24'hC00000, 24'h800000);
      repeat (4) @(negedge clk);
      start = 1'b1; a = 24'h123456; b = 24'h000001;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      check("ign.lat", 64'(done_cyc - k_cyc), 64'd26);
      check("ign.q", 64'(q), 64'h3000000);
      run_check("b2b", 24'h800000, 24'hC00000, 26'h1555555, 24'h400000, 1'b1, 1'b0, 1'b0, 26);
      @(negedge clk);

      // asynchronous reset in the middle of a division
      start_op(24'hFFFFFF, 24'h800001);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst.q", 64'(q), 64'd0);
      check("arst.r", 64'(r), 64'd0);
      check("arst.flags", 64'({busy, done, sticky, ovf, dbz}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      check("arst.no_done", 64'(dcount), 64'd0);
      run_check("max", 24'hFFFFFF, 24'hFFFFFF, 26'h2000000, 24'h0, 1'b0, 1'b0, 1'b0, 26);
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         mode = int'($urandom_range(0, 3));
         ra = W'($urandom);
         rb = W'($urandom);
         if (mode == 0) begin
            ra = ra | 24'h800000;
            rb = rb | 24'h800000;
         end else if (mode == 2) begin
            rb = '0;
         end else if (mode == 3) begin
            ra = ra | 24'h800000;
            rb = rb >> $urandom_range(1, 23);
         end
         model(ra, rb, eq, er, es, eo, ed, elat);
         run_check($sformatf("rnd%0d", i), ra, rb, eq, er, es, eo, ed, elat);
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            check("rnd.done_clear", 64'(done), 64'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
